alsu_driver: RTL and testbench
==============================

// Module: alsu_driver
// PURPOSE
//  Command initiator for the ALSU: accepts packed ALSU commands over a valid/ready
//  port, drives the ALSU input pins for a programmable number of cycles, waits out
//  the ALSU pipeline latency, captures out/leds and returns them on a valid/ready
//  response port. Sits between a host or test sequencer and one ALSU instance.
// PARAMETERS
//  LATENCY    2   cycles from last drive cycle to the ALSU result being visible (>=1)
//  HOLD_W     4   width of cmd_hold; a command is driven for cmd_hold+1 cycles
// PORTS
//  clk            in   1   clock, single domain
//  rst            in   1   synchronous, active-high reset
//  cmd_valid      in   1   command offered
//  cmd_ready      out  1   driver can accept a command
//  cmd_data       in   16  [2:0]a [5:3]b [8:6]opcode [9]cin [10]serial_in [11]red_op_a
//                          [12]red_op_b [13]bypass_a [14]bypass_b [15]direction
//  cmd_hold       in   HOLD_W  extra drive cycles (0 -> driven 1 cycle)
//  rsp_valid      out  1   response available
//  rsp_ready      in   1   response consumed
//  rsp_out        out  6   captured alsu_out
//  rsp_leds       out  16  captured alsu_leds
//  rsp_invalid    out  1   local invalid-command flag (see CONFIGURATION)
//  busy           out  1   state != IDLE
//  alsu_a, alsu_b, alsu_opcode  out 3 each   ALSU operand/opcode pins
//  alsu_cin, alsu_serial_in, alsu_red_op_a, alsu_red_op_b,
//  alsu_bypass_a, alsu_bypass_b, alsu_direction  out 1 each   ALSU control pins
//  alsu_out       in   6   ALSU result
//  alsu_leds      in   16  ALSU led bus
// BEHAVIOUR
//  - All outputs registered. Reset (sync): state IDLE, every alsu_* pin 0, rsp_* 0,
//    rsp_valid 0, cmd_ready 1, busy 0. Reset mid-operation drops the command, no response.
//  - Idle pin value = all zero (opcode AND, a=b=0): ALSU output settles to 0, leds 0.
//  - FSM IDLE -> DRIVE -> WAIT -> RESP -> IDLE.
//  - IDLE: cmd_ready=1. Handshake cmd_valid&cmd_ready in cycle t latches cmd_data and
//    cmd_hold; pins carry the command from cycle t+1; hold counter loaded with cmd_hold.
//  - DRIVE: pins held constant; counter decrements each cycle; when counter==0 the
//    cycle is the last drive cycle; next cycle pins return to zero, enter WAIT.
//    Command occupies cycles t+1 .. t+1+cmd_hold (cmd_hold+1 cycles, max 2^HOLD_W).
//  - WAIT: exactly LATENCY cycles; on the final WAIT cycle alsu_out/alsu_leds are
//    sampled into rsp_out/rsp_leds; next cycle RESP with rsp_valid=1.
//    rsp_valid first high in cycle t+2+cmd_hold+LATENCY.
//  - RESP: rsp_valid, rsp_out, rsp_leds, rsp_invalid stable until rsp_valid&rsp_ready;
//    that cycle -> IDLE (cmd_ready=1 next cycle). No command accepted outside IDLE;
//    cmd_ready=0 in DRIVE/WAIT/RESP. One command in flight at most.
//  - Multi-cycle ops: shift/rotate act once per drive cycle on the ALSU side, so the
//    result reflects cmd_hold+1 steps starting from out=0 (idle precondition).
//  - Invalid-case leds toggle per drive cycle: captured leds = 16'hFFFF if cmd_hold+1
//    is odd, 16'h0000 if even.
//  - cmd_data/cmd_hold ignored when not handshaken; rsp_ready ignored outside RESP.
// CONFIGURATION
//  ALSU_DRV_INVALID_FLAG_EN defined: rsp_invalid = latched (opcode==110 | opcode==111 |
//    ((red_op_a|red_op_b) & opcode not in {000,001})), valid with rsp_valid.
//  Not defined: rsp_invalid tied 0; port remains present.
// TESTING
//  ADD a=3,b=5,cin=1,hold=0 at t -> rsp_valid at t+4, rsp_out=9, rsp_leds=0
//  MUL a=7,b=7,hold=0 -> rsp_out=49, rsp_leds=0, rsp_invalid=0
//  SHIFT opcode=100,dir=1,serial_in=1,hold=3 -> rsp_out=6'b001111, rsp_valid at t+7
//  opcode=110,bypass_a=1,a=5,hold=2 -> rsp_out=5, rsp_leds=FFFF, rsp_invalid=1 (macro on)
//  rsp_ready low 5 cycles in RESP -> rsp_* stable, cmd_ready=0; 2nd cmd taken only after handshake
//  rst pulse during DRIVE -> next cycle IDLE, all alsu_* 0, cmd_ready=1, no rsp_valid

Source files
------------

// File: rtl/alsu_driver_if.sv
// Command/response bundle between a host sequencer and alsu_driver.
// master = host side, slave = driver side.
interface alsu_driver_if #(
    parameter int HOLD_W = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [15:0]       cmd_data;
    logic [HOLD_W-1:0] cmd_hold;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [5:0]        rsp_out;
    logic [15:0]       rsp_leds;
    logic              rsp_invalid;

    modport master (
        output cmd_valid, cmd_data, cmd_hold, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_out, rsp_leds, rsp_invalid
    );

    modport slave (
        input  cmd_valid, cmd_data, cmd_hold, rsp_ready,
        output cmd_ready, rsp_valid, rsp_out, rsp_leds, rsp_invalid
    );
endinterface

// File: rtl/alsu_driver.sv
// ALSU command initiator: drive pins for cmd_hold+1 cycles, wait out the
// ALSU latency, capture out/leds. ALSU_DRV_INVALID_FLAG_EN enables rsp_invalid.
module alsu_driver #(
    parameter int LATENCY = 2,
    parameter int HOLD_W  = 4
) (
    input  logic        clk,
    input  logic        rst,
    alsu_driver_if.slave bus,
    output logic        busy,
    output logic [2:0]  alsu_a,
    output logic [2:0]  alsu_b,
    output logic [2:0]  alsu_opcode,
    output logic        alsu_cin,
    output logic        alsu_serial_in,
    output logic        alsu_red_op_a,
    output logic        alsu_red_op_b,
    output logic        alsu_bypass_a,
    output logic        alsu_bypass_b,
    output logic        alsu_direction,
    input  logic [5:0]  alsu_out,
    input  logic [15:0] alsu_leds
);
    localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        WAIT,
        RESP
    } state_t;

    state_t            state, state_nx;
    logic [HOLD_W-1:0] hold_q, hold_nx;
    logic [LAT_W-1:0]  wait_q, wait_nx;
    logic [15:0]       pins_q, pins_nx;
    logic [5:0]        out_q, out_nx;
    logic [15:0]       leds_q, leds_nx;
    logic              valid_q, valid_nx;
    logic              ready_q;
    logic              busy_q;
    logic              take;
    logic              sample;

    assign take   = (state == IDLE) && bus.cmd_valid;
    assign sample = (state == WAIT) && (wait_q == '0);

    // Next-state and next-register values; pins image uses cmd_data layout.
    always_comb begin
        state_nx = state;
        hold_nx  = hold_q;
        wait_nx  = wait_q;
        pins_nx  = pins_q;
        out_nx   = out_q;
        leds_nx  = leds_q;
        valid_nx = valid_q;
        unique case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    state_nx = DRIVE;
                    pins_nx  = bus.cmd_data;
                    hold_nx  = bus.cmd_hold;
                end
            end
            DRIVE: begin
                if (hold_q == '0) begin
                    state_nx = WAIT;
                    pins_nx  = '0;
                    wait_nx  = LAT_W'(LATENCY - 1);
                end else begin
                    hold_nx = hold_q - HOLD_W'(1);
                end
            end
            WAIT: begin
                if (wait_q == '0) begin
                    state_nx = RESP;
                    out_nx   = alsu_out;
                    leds_nx  = alsu_leds;
                    valid_nx = 1'b1;
                end else begin
                    wait_nx = wait_q - LAT_W'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_nx = IDLE;
                    valid_nx = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and output registers; reset drops any command in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            hold_q  <= '0;
            wait_q  <= '0;
            pins_q  <= '0;
            out_q   <= '0;
            leds_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_nx;
            hold_q  <= hold_nx;
            wait_q  <= wait_nx;
            pins_q  <= pins_nx;
            out_q   <= out_nx;
            leds_q  <= leds_nx;
            valid_q <= valid_nx;
            ready_q <= (state_nx == IDLE);
            busy_q  <= (state_nx != IDLE);
        end
    end

`ifdef ALSU_DRV_INVALID_FLAG_EN
    logic [2:0] op;
    logic       bad;
    logic       bad_q;
    logic       inv_q;

    assign op  = bus.cmd_data[8:6];
    assign bad = (op == 3'b110) || (op == 3'b111) ||
                 ((bus.cmd_data[11] | bus.cmd_data[12]) && (op[2:1] != 2'b00));

    // Classify on accept, publish together with the captured result.
    always_ff @(posedge clk) begin
        if (rst) begin
            bad_q <= 1'b0;
            inv_q <= 1'b0;
        end else begin
            if (take)
                bad_q <= bad;
            if (sample)
                inv_q <= bad_q;
        end
    end

    assign bus.rsp_invalid = inv_q;
`else
    assign bus.rsp_invalid = 1'b0;
`endif

    assign bus.cmd_ready = ready_q;
    assign bus.rsp_valid = valid_q;
    assign bus.rsp_out   = out_q;
    assign bus.rsp_leds  = leds_q;
    assign busy          = busy_q;

    assign alsu_a         = pins_q[2:0];
    assign alsu_b         = pins_q[5:3];
    assign alsu_opcode    = pins_q[8:6];
    assign alsu_cin       = pins_q[9];
    assign alsu_serial_in = pins_q[10];
    assign alsu_red_op_a  = pins_q[11];
    assign alsu_red_op_b  = pins_q[12];
    assign alsu_bypass_a  = pins_q[13];
    assign alsu_bypass_b  = pins_q[14];
    assign alsu_direction = pins_q[15];
endmodule

// File: tb/tb_alsu_driver.sv
// Testbench for alsu_driver with a clocked ALSU stand-in (latency 2)
// and a closed-form reference for the captured response.
module tb_alsu_driver;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy;
    logic [2:0]  alsu_a, alsu_b, alsu_opcode;
    logic        alsu_cin, alsu_serial_in, alsu_red_op_a, alsu_red_op_b;
    logic        alsu_bypass_a, alsu_bypass_b, alsu_direction;
    logic [5:0]  alsu_out;
    logic [15:0] alsu_leds;
    logic [15:0] pins;

    int n_checks = 0;
    int n_fail   = 0;

    alsu_driver_if #(.HOLD_W(4)) bus ();

    alsu_driver #(.LATENCY(2), .HOLD_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .busy           (busy),
        .alsu_a         (alsu_a),
        .alsu_b         (alsu_b),
        .alsu_opcode    (alsu_opcode),
        .alsu_cin       (alsu_cin),
        .alsu_serial_in (alsu_serial_in),
        .alsu_red_op_a  (alsu_red_op_a),
        .alsu_red_op_b  (alsu_red_op_b),
        .alsu_bypass_a  (alsu_bypass_a),
        .alsu_bypass_b  (alsu_bypass_b),
        .alsu_direction (alsu_direction),
        .alsu_out       (alsu_out),
        .alsu_leds      (alsu_leds)
    );

    always #5 clk = ~clk;

    assign pins = {alsu_direction, alsu_bypass_b, alsu_bypass_a,
                   alsu_red_op_b, alsu_red_op_a, alsu_serial_in,
                   alsu_cin, alsu_opcode, alsu_b, alsu_a};

    function automatic bit is_bad(input logic [15:0] c);
        int op;
        op = int'(c[8:6]);
        return (op >= 6) || ((c[11] | c[12]) && op >= 2);
    endfunction

    // ALSU stand-in: registered inputs, registered out/leds.
    function automatic logic [5:0] alsu_step(input logic [15:0] c,
                                             input logic [5:0] o);
        logic [2:0] a, b;
        a = c[2:0];
        b = c[5:3];
        if (c[13]) return {3'b0, a};
        if (c[14]) return {3'b0, b};
        if (is_bad(c)) return 6'd0;
        case (c[8:6])
            3'd0: return c[11] ? {5'b0, &a} : c[12] ? {5'b0, &b} : {3'b0, a & b};
            3'd1: return c[11] ? {5'b0, ^a} : c[12] ? {5'b0, ^b} : {3'b0, a ^ b};
            3'd2: return {3'b0, a} + {3'b0, b} + {5'b0, c[9]};
            3'd3: return {3'b0, a} * {3'b0, b};
            3'd4: return c[15] ? {o[4:0], c[10]} : {c[10], o[5:1]};
            3'd5: return c[15] ? {o[4:0], o[5]} : {o[0], o[5:1]};
            default: return 6'd0;
        endcase
    endfunction

    logic [15:0] p_m    = '0;
    logic [5:0]  out_m  = '0;
    logic [15:0] leds_m = '0;

    // ALSU stand-in pipeline.
    always @(posedge clk) begin
        p_m    <= pins;
        out_m  <= alsu_step(p_m, out_m);
        leds_m <= is_bad(p_m) ? ~leds_m : 16'h0000;
    end

    assign alsu_out  = out_m;
    assign alsu_leds = leds_m;

    // Reference: result after n drive cycles, starting from out=0.
    function automatic logic [5:0] ref_out(input logic [15:0] c, input int n);
        int a, b, r;
        a = int'(c[2:0]);
        b = int'(c[5:3]);
        if (c[13]) return 6'(a);
        if (c[14]) return 6'(b);
        if (is_bad(c)) return 6'd0;
        r = 0;
        case (int'(c[8:6]))
            0: r = c[11] ? int'(a == 7) : c[12] ? int'(b == 7) : (a & b);
            1: r = c[11] ? $countones(c[2:0]) % 2 :
                   c[12] ? $countones(c[5:3]) % 2 : (a ^ b);
            2: r = a + b + int'(c[9]);
            3: r = a * b;
            4: begin
                if (!c[10]) r = 0;
                else if (n >= 6) r = 63;
                else if (c[15]) r = (1 << n) - 1;
                else r = 63 - ((1 << (6 - n)) - 1);
            end
            default: r = 0;
        endcase
        return 6'(r);
    endfunction

    function automatic logic [15:0] ref_leds(input logic [15:0] c, input int n);
        if (is_bad(c) && (n % 2 == 1)) return 16'hFFFF;
        return 16'h0000;
    endfunction

    function automatic logic ref_inv(input logic [15:0] c);
`ifdef ALSU_DRV_INVALID_FLAG_EN
        return is_bad(c);
`else
        return (c == 16'hDEAD) && 1'b0;
`endif
    endfunction

    function automatic logic [15:0] mk(input int a, input int b, input int op,
                                       input bit cin, input bit si, input bit ba,
                                       input bit dir);
        logic [15:0] c;
        c       = '0;
        c[2:0]  = 3'(a);
        c[5:3]  = 3'(b);
        c[8:6]  = 3'(op);
        c[9]    = cin;
        c[10]   = si;
        c[13]   = ba;
        c[15]   = dir;
        return c;
    endfunction

    task automatic send(input logic [15:0] d, input logic [3:0] h);
        bus.cmd_data  = d;
        bus.cmd_hold  = h;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = 16'($urandom);
        bus.cmd_hold  = 4'($urandom);
    endtask

    task automatic wait_rsp(output int n, input bit jitter);
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 200) begin
            if (jitter) bus.rsp_ready = 1'($urandom);
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        bus.cmd_data  = '0;
        bus.cmd_hold  = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_cmd_ready got=%b want=1", bus.cmd_ready);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy got=%b want=0", busy);
        end
        n_checks++;
        if ({bus.rsp_valid, bus.rsp_out, bus.rsp_leds, bus.rsp_invalid} !== '0) begin
            n_fail++;
            $display("FAIL reset_rsp got=%b/%h/%h/%b want=0", bus.rsp_valid,
                     bus.rsp_out, bus.rsp_leds, bus.rsp_invalid);
        end
        n_checks++;
        if (pins !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_pins got=%h want=0000", pins);
        end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        logic [15:0] cmds [4];
        logic [3:0]  holds [4];
        logic [5:0]  outs [4];
        logic [15:0] leds [4];
        logic        invs [4];
        int n;
        cmds[0] = mk(3, 5, 2, 1, 0, 0, 0); holds[0] = 0; outs[0] = 9;
        cmds[1] = mk(7, 7, 3, 0, 0, 0, 0); holds[1] = 0; outs[1] = 49;
        cmds[2] = mk(0, 0, 4, 0, 1, 0, 1); holds[2] = 3; outs[2] = 6'b001111;
        cmds[3] = mk(5, 0, 6, 0, 0, 1, 0); holds[3] = 2; outs[3] = 5;
        leds[0] = 16'h0; leds[1] = 16'h0; leds[2] = 16'h0; leds[3] = 16'hFFFF;
        invs[0] = 0; invs[1] = 0; invs[2] = 0;
`ifdef ALSU_DRV_INVALID_FLAG_EN
        invs[3] = 1;
`else
        invs[3] = 0;
`endif
        for (int i = 0; i < 4; i++) begin
            send(cmds[i], holds[i]);
            n_checks++;
            if ({pins, busy, bus.cmd_ready} !== {cmds[i], 2'b10}) begin
                n_fail++;
                $display("FAIL dir%0d_drive pins=%h busy=%b rdy=%b want pins=%h busy=1 rdy=0",
                         i, pins, busy, bus.cmd_ready, cmds[i]);
            end
            wait_rsp(n, 1'b0);
            n_checks++;
            if (n != 3 + int'(holds[i])) begin
                n_fail++;
                $display("FAIL dir%0d_latency got=%0d want=%0d", i, n, 3 + int'(holds[i]));
            end
            n_checks++;
            if ({bus.rsp_out, bus.rsp_leds, bus.rsp_invalid} !== {outs[i], leds[i], invs[i]}) begin
                n_fail++;
                $display("FAIL dir%0d_rsp got=%0d/%h/%b want=%0d/%h/%b", i, bus.rsp_out,
                         bus.rsp_leds, bus.rsp_invalid, outs[i], leds[i], invs[i]);
            end
            bus.rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.rsp_ready = 1'b0;
            n_checks++;
            if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01) begin
                n_fail++;
                $display("FAIL dir%0d_release vld=%b rdy=%b want vld=0 rdy=1",
                         i, bus.rsp_valid, bus.cmd_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] c1, c2;
        logic [5:0]  so;
        logic [15:0] sl;
        logic        si;
        int n;
        c1 = mk(6, 3, 2, 0, 0, 0, 0);
        c2 = mk(2, 3, 3, 0, 0, 0, 0);
        send(c1, 4'd1);
        wait_rsp(n, 1'b0);
        so = bus.rsp_out;
        sl = bus.rsp_leds;
        si = bus.rsp_invalid;
        n_checks++;
        if (so !== 6'd9) begin
            n_fail++;
            $display("FAIL bp_first_out got=%0d want=9", so);
        end
        bus.cmd_data  = c2;
        bus.cmd_hold  = 4'd0;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if ({bus.rsp_valid, bus.cmd_ready, bus.rsp_out, bus.rsp_leds, bus.rsp_invalid}
                !== {2'b10, so, sl, si}) begin
                n_fail++;
                $display("FAIL bp_hold%0d vld=%b rdy=%b out=%0d want vld=1 rdy=0 out=%0d",
                         i, bus.rsp_valid, bus.cmd_ready, bus.rsp_out, so);
            end
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        n_checks++;
        if ({bus.rsp_valid, bus.cmd_ready, busy} !== 3'b010) begin
            n_fail++;
            $display("FAIL bp_release vld=%b rdy=%b busy=%b want 0/1/0",
                     bus.rsp_valid, bus.cmd_ready, busy);
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        n_checks++;
        if (pins !== c2) begin
            n_fail++;
            $display("FAIL bp_second_pins got=%h want=%h", pins, c2);
        end
        wait_rsp(n, 1'b0);
        n_checks++;
        if ({n, bus.rsp_out} !== {32'd3, 6'd6}) begin
            n_fail++;
            $display("FAIL bp_second_rsp lat=%0d out=%0d want lat=3 out=6", n, bus.rsp_out);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_drive();
        int seen;
        send(mk(0, 0, 4, 0, 1, 0, 1), 4'd10);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++;
        if ({busy, bus.cmd_ready, pins} !== {2'b01, 16'h0}) begin
            n_fail++;
            $display("FAIL rst_mid busy=%b rdy=%b pins=%h want 0/1/0000",
                     busy, bus.cmd_ready, pins);
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.rsp_valid === 1'b1) seen++;
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL rst_mid_no_rsp got=%0d want=0", seen);
        end
    endtask

    task automatic test_random();
        logic [15:0] c;
        logic [3:0]  h;
        int n, k;
        for (int i = 0; i < 40; i++) begin
            c = 16'($urandom);
            h = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
            k = int'(h) + 1;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            send(c, h);
            wait_rsp(n, 1'b1);
            bus.rsp_ready = 1'b0;
            n_checks++;
            if (n != k + 2) begin
                n_fail++;
                $display("FAIL rnd%0d_latency got=%0d want=%0d", i, n, k + 2);
            end
            n_checks++;
            if ({bus.rsp_out, bus.rsp_leds, bus.rsp_invalid} !==
                {ref_out(c, k), ref_leds(c, k), ref_inv(c)}) begin
                n_fail++;
                $display("FAIL rnd%0d_rsp cmd=%h hold=%0d got=%0d/%h/%b want=%0d/%h/%b",
                         i, c, h, bus.rsp_out, bus.rsp_leds, bus.rsp_invalid,
                         ref_out(c, k), ref_leds(c, k), ref_inv(c));
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            bus.rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.rsp_ready = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] c;
        int n;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            c = mk(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 3)), 1'($urandom), 0, 0, 0);
            n_checks++;
            if (bus.cmd_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b%0d_ready got=%b want=1", i, bus.cmd_ready);
            end
            send(c, 4'd0);
            wait_rsp(n, 1'b0);
            n_checks++;
            if ({n, bus.rsp_out, bus.rsp_leds} !== {32'd3, ref_out(c, 1), 16'h0}) begin
                n_fail++;
                $display("FAIL b2b%0d_rsp lat=%0d out=%0d want lat=3 out=%0d",
                         i, n, bus.rsp_out, ref_out(c, 1));
            end
            @(posedge clk);
            #1;
        end
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_drive();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
